// File: rtl/pri_requester.sv
// Per-port priority request queues feeding an external arbiter.
// Waiting heads are aged and boosted; granted heads are popped and reported one cycle later.
module pri_requester #(
    parameter int unsigned N      = 4,
    parameter int unsigned P      = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AGE_TH = 8,
    localparam int unsigned W     = (P > 1) ? $clog2(P) : 1,
    localparam int unsigned NW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    push,
    input  logic [N*W-1:0]  push_pri,
    output logic [N-1:0]    full,
    output logic [N-1:0]    req,
    output logic [N*W-1:0]  pri_req,
    input  logic [N-1:0]    gnt,
    input  logic            any_gnt,
    output logic            pop_valid,
    output logic [NW-1:0]   pop_port,
    output logic [W-1:0]    pop_pri,
    output logic            err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = (AGE_TH > 1) ? $clog2(AGE_TH) : 1;

    logic [W-1:0]  mem_q   [N][DEPTH];
    logic [AW-1:0] rptr_q  [N];
    logic [AW-1:0] rptr_d  [N];
    logic [AW-1:0] wptr_q  [N];
    logic [AW-1:0] wptr_d  [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [GW-1:0] age_q   [N];
    logic [GW-1:0] age_d   [N];
    logic [W-1:0]  boost_q [N];
    logic [W-1:0]  boost_d [N];
    logic [W-1:0]  head    [N];
    logic [W-1:0]  in_pri  [N];
    logic [W:0]    boosted [N];

    logic [N-1:0]  pop, push_ok, push_ovf;
    logic          gnt_onehot, gnt_err;
    logic [NW-1:0] gnt_idx;
    logic          err_q, err_d;
    logic          pop_valid_q;
    logic [NW-1:0] pop_port_q;
    logic [W-1:0]  pop_pri_q;

    // Grant decode: only a qualified one-hot grant to a non-empty port pops.
    always_comb begin
        gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
        gnt_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = NW'(i);
        end
        pop     = (any_gnt && gnt_onehot) ? (gnt & req) : '0;
        gnt_err = (gnt != '0) && (!any_gnt || !gnt_onehot || ((gnt & req) == '0));
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head[i]    = mem_q[i][rptr_q[i]];
            req[i]     = (cnt_q[i] != '0);
            full[i]    = (cnt_q[i] == CW'(DEPTH));
            boosted[i] = {1'b0, head[i]} + {1'b0, boost_q[i]};
            if (!req[i]) begin
                pri_req[i*W +: W] = '0;
            end else if (boosted[i] > (W+1)'(P - 1)) begin
                pri_req[i*W +: W] = W'(P - 1);
            end else begin
                pri_req[i*W +: W] = boosted[i][W-1:0];
            end
        end
    end

    always_comb begin
        err_d = err_q | gnt_err;
        for (int i = 0; i < N; i++) begin
            in_pri[i]   = push_pri[i*W +: W];
            // A full port still accepts a push when it pops on the same edge.
            push_ok[i]  = push[i] && (in_pri[i] != '0) && (!full[i] || pop[i]);
            push_ovf[i] = push[i] && (in_pri[i] != '0) && full[i] && !pop[i];
            if (push_ovf[i]) err_d = 1'b1;

            rptr_d[i] = rptr_q[i] + AW'(pop[i]);
            wptr_d[i] = wptr_q[i] + AW'(push_ok[i]);
            cnt_d[i]  = cnt_q[i];
            if (push_ok[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CW'(1);
            if (pop[i] && !push_ok[i]) cnt_d[i] = cnt_q[i] - CW'(1);

            age_d[i]   = age_q[i];
            boost_d[i] = boost_q[i];
            if (pop[i]) begin
                age_d[i]   = '0;
                boost_d[i] = '0;
            end else if (req[i]) begin
                if (age_q[i] == GW'(AGE_TH - 1)) begin
                    age_d[i] = '0;
                    if (boost_q[i] != W'(P - 1)) boost_d[i] = boost_q[i] + W'(1);
                end else begin
                    age_d[i] = age_q[i] + GW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                rptr_q[i]  <= '0;
                wptr_q[i]  <= '0;
                cnt_q[i]   <= '0;
                age_q[i]   <= '0;
                boost_q[i] <= '0;
            end
            err_q       <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_port_q  <= '0;
            pop_pri_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rptr_q[i]  <= rptr_d[i];
                wptr_q[i]  <= wptr_d[i];
                cnt_q[i]   <= cnt_d[i];
                age_q[i]   <= age_d[i];
                boost_q[i] <= boost_d[i];
            end
            err_q       <= err_d;
            pop_valid_q <= |pop;
            if (|pop) begin
                pop_port_q <= gnt_idx;
                pop_pri_q  <= head[gnt_idx];
            end
        end
    end

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_ok[i]) mem_q[i][wptr_q[i]] <= in_pri[i];
        end
    end

    assign err       = err_q;
    assign pop_valid = pop_valid_q;
    assign pop_port  = pop_port_q;
    assign pop_pri   = pop_pri_q;

endmodule

// File: tb/tb_pri_requester.sv
// Directed bench for pri_requester: pops are checked by a scoreboard monitor,
// status outputs by inline checks after each edge.
module tb_pri_requester;

    localparam int N = 4;
    localparam int P = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   push;
    logic [N*W-1:0] push_pri;
    logic [N-1:0]   full, req;
    logic [N*W-1:0] pri_req;
    logic [N-1:0]   gnt;
    logic           any_gnt;
    logic           pop_valid;
    logic [1:0]     pop_port;
    logic [W-1:0]   pop_pri;
    logic           err;

    int n_vec = 0;
    int n_bad = 0;
    logic [5:0] sb [$];  // {port, pri}

    pri_requester #(.N(N), .P(P), .DEPTH(4), .AGE_TH(8)) dut (
        .clk(clk), .reset(reset), .push(push), .push_pri(push_pri),
        .full(full), .req(req), .pri_req(pri_req), .gnt(gnt), .any_gnt(any_gnt),
        .pop_valid(pop_valid), .pop_port(pop_port), .pop_pri(pop_pri), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pop_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pop: got port %0d pri %0d, required no pop",
                         pop_port, pop_pri);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                if ({pop_port, pop_pri} !== e) begin
                    n_bad++;
                    $display("FAIL pop_report: got port %0d pri %0d, required port %0d pri %0d",
                             pop_port, pop_pri, e[5:4], e[3:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            push    = '0;
            gnt     = '0;
            any_gnt = 1'b0;
            reset   = 1'b0;
        end
    endtask

    task automatic do_push(input int port, input int pri);
        push[port]           = 1'b1;
        push_pri[port*W +: W] = W'(pri);
    endtask

    task automatic do_gnt(input int port, input int exp_pri);
        gnt[port] = 1'b1;
        any_gnt   = 1'b1;
        sb.push_back({2'(port), 4'(exp_pri)});
    endtask

    function automatic logic [W-1:0] prq(input int port);
        return pri_req[port*W +: W];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_pri_req"}, 32'(pri_req), 0);
        chk({tag, "_pop_valid"}, 32'(pop_valid), 0);
        chk({tag, "_pop_port"}, 32'(pop_port), 0);
        chk({tag, "_pop_pri"}, 32'(pop_pri), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        push = '0; push_pri = '0; gnt = '0; any_gnt = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        chk_all_zero("reset");

        // Single push then grant on port 2.
        do_push(2, 5);
        tick();
        chk("p2_req", 32'(req), 32'b0100);
        chk("p2_pri_req", 32'(prq(2)), 5);
        do_gnt(2, 5);
        tick();
        chk("p2_req_after_pop", 32'(req), 0);

        // Fill port 0, overflow, drain in order.
        for (int k = 1; k <= 4; k++) begin
            do_push(0, k);
            tick();
        end
        chk("p0_full", 32'(full), 32'b0001);
        chk("p0_err_before_ovf", 32'(err), 0);
        do_push(0, 9);
        tick();
        chk("p0_err_ovf", 32'(err), 1);
        chk("p0_full_ovf", 32'(full), 32'b0001);
        for (int k = 1; k <= 4; k++) begin
            do_gnt(0, k);
            tick();
        end
        chk("p0_drained", 32'(req), 0);
        reset = 1'b1;
        tick();
        chk("err_cleared", 32'(err), 0);

        // Aging on port 1: boost every 8 waiting cycles.
        do_push(1, 3);
        tick();
        chk("age_start", 32'(prq(1)), 3);
        do_push(1, 2);
        tick();
        tick(6);
        chk("age_7", 32'(prq(1)), 3);
        tick();
        chk("age_8", 32'(prq(1)), 4);
        tick(8);
        chk("age_16", 32'(prq(1)), 5);
        do_gnt(1, 3);
        tick();
        chk("age_next_head", 32'(prq(1)), 2);
        do_gnt(1, 2);
        tick();
        chk("age_drained", 32'(req), 0);

        // Saturation on port 3.
        do_push(3, P - 1);
        tick();
        tick(8);
        chk("sat_8", 32'(prq(3)), P - 1);
        tick(16);
        chk("sat_24", 32'(prq(3)), P - 1);
        do_gnt(3, P - 1);
        tick();

        // Push into a full port while it pops.
        for (int k = 4; k <= 7; k++) begin
            do_push(0, k);
            tick();
        end
        do_push(0, 8);
        do_gnt(0, 4);
        tick();
        chk("fullpp_full", 32'(full), 32'b0001);
        chk("fullpp_err", 32'(err), 0);
        for (int k = 5; k <= 8; k++) begin
            do_gnt(0, k);
            tick();
        end
        chk("fullpp_drained", 32'(req), 0);

        // Protocol errors.
        do_push(2, 0);
        tick();
        chk("zero_pri_dropped", 32'(req), 0);
        gnt = 4'b0010; any_gnt = 1'b1;
        tick();
        chk("empty_gnt_pop_valid", 32'(pop_valid), 0);
        chk("empty_gnt_err", 32'(err), 1);
        reset = 1'b1;
        tick();
        gnt = 4'b0100; any_gnt = 1'b0;
        tick();
        chk("unqual_gnt_err", 32'(err), 1);
        reset = 1'b1;
        tick();
        do_push(0, 1);
        tick();
        gnt = 4'b0011; any_gnt = 1'b1;
        tick();
        chk("multihot_pop_valid", 32'(pop_valid), 0);
        chk("multihot_err", 32'(err), 1);
        chk("multihot_req", 32'(req), 32'b0001);

        // Reset mid-queue overrides push and grant.
        do_push(1, 7);
        gnt = 4'b0001; any_gnt = 1'b1;
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");

        tick(3);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pri_requester.md
PRI_REQUESTER -- requirements
Module: pri_requester

Interface
REQ-001 Parameters: N, default 4, number of requester ports.
REQ-002 Parameters: P, default 16, number of priority levels; level 0 means "no request".
REQ-003 Parameters: DEPTH, default 4, entries per port queue (power of 2).
REQ-004 Parameters: AGE_TH, default 8, waiting cycles per one-level priority boost.
REQ-005 Ports: clk  in  1  single clock, rising edge.
REQ-006 Ports: reset  in  1  synchronous, active-high reset.
REQ-007 Ports: push  in  [N-1:0]  per-port enqueue strobe.
REQ-008 Ports: push_pri  in  [clog2(P)-1:0] x N  priority of the pushed entry, per port.
REQ-009 Ports: full  out  [N-1:0]  port queue holds DEPTH entries.
REQ-010 Ports: req  out  [N-1:0]  port queue non-empty.
REQ-011 Ports: pri_req  out  [clog2(P)-1:0] x N  effective head priority presented to the arbiter.
REQ-012 Ports: gnt  in  [N-1:0]  one-hot grant returned by the arbiter.
REQ-013 Ports: any_gnt  in  1  grant qualifier.
REQ-014 Ports: pop_valid  out  1  registered pop report.
REQ-015 Ports: pop_port  out  [clog2(N)-1:0]  index of the granted port.
REQ-016 Ports: pop_pri  out  [clog2(P)-1:0]  stored, unboosted priority of the popped entry.
REQ-017 Ports: err  out  1  sticky protocol error flag.

Function
REQ-018 Each port SHALL own an independent FIFO of DEPTH entries with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-019 Accepted push SHALL write push_pri at the tail; occupancy and full/req update on the next edge.
REQ-020 Push with push_pri==0 SHALL be dropped silently; no state change.
REQ-021 Push to a full port SHALL be dropped and set err, unless that port pops in the same cycle, in which case the push is accepted and occupancy stays DEPTH.
REQ-022 Push to an empty port SHALL NOT be visible on req/pri_req until the following cycle; no same-cycle bypass.
REQ-023 req[i] SHALL equal (occupancy[i]!=0); pri_req[i] SHALL be 0 when req[i]==0.
REQ-024 pri_req[i] SHALL be min(head_pri[i] + boost[i], P-1), computed combinationally from registered state.
REQ-025 Per-port age counter SHALL increment each cycle req[i]==1 and port i is not popped; on reaching AGE_TH-1 it SHALL clear and boost[i] SHALL increment, saturating at P-1.
REQ-026 Pop SHALL occur on port i when any_gnt==1, gnt[i]==1 and gnt is one-hot; the head entry is removed and age[i] and boost[i] clear on the same edge.
REQ-027 gnt asserted to an empty port, multi-hot gnt with any_gnt==1, or gnt!=0 with any_gnt==0 SHALL pop nothing and set err.
REQ-028 pop_valid, pop_port and pop_pri SHALL be registered one cycle after the granting cycle; pop_valid SHALL be a one-cycle pulse per pop; pop_port and pop_pri hold their last value otherwise.
REQ-029 Push and pop on the same port in the same cycle SHALL both take effect; occupancy is unchanged; the new entry's age starts at 0.
REQ-030 At most one pop per cycle (one-hot gnt); pushes on all N ports SHALL be accepted in parallel.

Reset
REQ-031 reset==1 at a clk edge SHALL empty all queues and clear pointers, occupancy, age, boost and err; full=0, req=0, pri_req=0, pop_valid=0, pop_port=0, pop_pri=0.
REQ-032 Reset SHALL take priority over push and gnt in the same cycle, including mid-operation; in-flight entries are discarded.

Verification
REQ-033 Push port 2 pri=5, then gnt=4'b0100 with any_gnt=1 one cycle later -> req[2]=1, pri_req[2]=5; next cycle pop_valid=1, pop_port=2, pop_pri=5, req[2]=0.
REQ-034 Push 4 entries (pri 1,2,3,4) to port 0, then a 5th push -> full[0]=1, 5th dropped, err=1; four grants pop 1,2,3,4 in order.
REQ-035 Port 1 holds pri=3, no grant for 2*AGE_TH cycles -> pri_req[1] steps to 4 then 5; grant -> pop_pri=3 and the next head restarts unboosted.
REQ-036 Port 3 holds pri=P-1, no grant for 3*AGE_TH cycles -> pri_req[3] stays P-1.
REQ-037 Port 0 full, push and gnt=4'b0001 in the same cycle -> push accepted, full[0] stays 1, err stays 0, pop_pri = old head.
REQ-038 Grant to empty port 1, and gnt=4'b0011 -> no pop, pop_valid=0, err=1; reset mid-queue -> all outputs 0 on the next cycle.
